// File: rtl/cpu_pkg.sv
// Shared CPU definitions: address geometry, reset vector and the
// program-counter source select encoding.
package cpu_pkg;

  localparam int          ADDR_WIDTH   = 32;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam int          INSTR_BYTES  = 4;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_HOLD   = 2'd1,
    PC_BRANCH = 2'd2,
    PC_JUMP   = 2'd3
  } pc_sel_t;

  // Redirects win over stall so a taken control transfer is never lost.
  function automatic pc_sel_t pick_sel(input logic jump, input logic branch_taken,
                                       input logic stall);
    if (jump)              return PC_JUMP;
    else if (branch_taken) return PC_BRANCH;
    else if (stall)        return PC_HOLD;
    else                   return PC_SEQ;
  endfunction

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC select: priority mux, target word alignment and
// the misaligned-target flag.
module pc_next_logic
  import cpu_pkg::*;
#(
  parameter int WIDTH = ADDR_WIDTH
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] seq_pc,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  output logic [WIDTH-1:0] next_pc,
  output logic             target_misaligned
);

  pc_sel_t          sel;
  logic [WIDTH-1:0] raw_target;

  assign sel = pick_sel(jump, branch_taken, stall);

  // Unselected targets never reach the outputs, so X on them stays contained.
  always_comb begin
    raw_target = '0;
    case (sel)
      PC_JUMP:   raw_target = jump_target;
      PC_BRANCH: raw_target = branch_target;
      default:   raw_target = '0;
    endcase
  end

  always_comb begin
    next_pc           = seq_pc;
    target_misaligned = 1'b0;
    case (sel)
      PC_JUMP, PC_BRANCH: begin
        next_pc           = {raw_target[WIDTH-1:2], 2'b00};
        target_misaligned = |raw_target[1:0];
      end
      PC_HOLD: next_pc = pc;
      default: next_pc = seq_pc;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: fetch address register plus next-address select.
// PC_out updates every rising edge to next_PC; rst (active low) is asynchronous.
module pc_unit #(
  parameter int               WIDTH        = cpu_pkg::ADDR_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(cpu_pkg::RESET_VECTOR),
  parameter int               INC          = cpu_pkg::INSTR_BYTES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  output logic [WIDTH-1:0] PC_out,
  output logic [WIDTH-1:0] next_PC,
  output logic [WIDTH-1:0] pc_plus_inc,
  output logic             target_misaligned
);
  import cpu_pkg::*;

  // Wraps modulo 2^WIDTH by construction; no carry-out is kept.
  assign pc_plus_inc = PC_out + WIDTH'(INC);

  pc_next_logic #(.WIDTH(WIDTH)) u_next (
    .pc                (PC_out),
    .seq_pc            (pc_plus_inc),
    .stall             (stall),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .jump              (jump),
    .jump_target       (jump_target),
    .next_pc           (next_PC),
    .target_misaligned (target_misaligned)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) PC_out <= RESET_VECTOR;
    else      PC_out <= next_PC;
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset, sequential fetch, stall, redirect
// priority, alignment, wrap-around and asynchronous reset mid-run.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] PC_out;
  logic [31:0] next_PC;
  logic [31:0] pc_plus_inc;
  logic        target_misaligned;

  int n_chk  = 0;
  int n_fail = 0;

  pc_unit dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .jump              (jump),
    .jump_target       (jump_target),
    .PC_out            (PC_out),
    .next_PC           (next_PC),
    .pc_plus_inc       (pc_plus_inc),
    .target_misaligned (target_misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Step past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_target = '0; jump_target = '0;
    #2;
    chk("rst_pc", PC_out, 32'h0);
    chk("rst_next", next_PC, 32'h4);
    chk("rst_inc", pc_plus_inc, 32'h4);
    tick();
    chk("rst_hold", PC_out, 32'h0);
    rst = 1'b1;
    tick(); chk("seq_4", PC_out, 32'h4);  chk("seq_next", next_PC, 32'h8);
    tick(); chk("seq_8", PC_out, 32'h8);

    stall = 1'b1; #1;
    chk("stall_next", next_PC, 32'h8);
    tick(); chk("stall_1", PC_out, 32'h8);
    tick(); chk("stall_2", PC_out, 32'h8);
    chk("stall_inc", pc_plus_inc, 32'hC);
    stall = 1'b0;
    tick(); chk("stall_rel", PC_out, 32'hC);

    branch_taken = 1'b1; branch_target = 32'h100; #1;
    chk("br_next", next_PC, 32'h100);
    chk("br_mis", {31'b0, target_misaligned}, 32'h0);
    tick(); chk("br_pc", PC_out, 32'h100);

    jump = 1'b1; jump_target = 32'h200; #1;
    chk("jb_next", next_PC, 32'h200);
    tick(); chk("jb_pc", PC_out, 32'h200);

    branch_taken = 1'b0; stall = 1'b1; jump_target = 32'h300;
    tick(); chk("js_pc", PC_out, 32'h300);
    stall = 1'b0;

    jump_target = 32'h103; #1;
    chk("jmis_flag", {31'b0, target_misaligned}, 32'h1);
    chk("jmis_next", next_PC, 32'h100);
    tick(); chk("jmis_pc", PC_out, 32'h100);

    jump = 1'b0; branch_taken = 1'b1; branch_target = 32'h102; #1;
    chk("bmis_flag", {31'b0, target_misaligned}, 32'h1);
    chk("bmis_next", next_PC, 32'h100);
    jump = 1'b1; jump_target = 32'h200; branch_target = 32'h101; #1;
    chk("sel_aligned", {31'b0, target_misaligned}, 32'h0);

    jump = 1'b0; branch_taken = 1'b0; jump_target = 'x; branch_target = 'x; #1;
    chk("nox_flag", {31'b0, target_misaligned}, 32'h0);
    chk("nox_next", next_PC, 32'h104);

    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    tick(); chk("wrap_top", PC_out, 32'hFFFF_FFFC);
    chk("wrap_inc0", pc_plus_inc, 32'h0);
    jump = 1'b0;
    tick(); chk("wrap_pc", PC_out, 32'h0);
    chk("wrap_inc", pc_plus_inc, 32'h4);

    jump = 1'b1; jump_target = 32'h3C;
    tick(); jump = 1'b0;
    tick(); chk("run_40", PC_out, 32'h40);
    rst = 1'b0; #1;
    chk("arst_pc", PC_out, 32'h0);
    chk("arst_next", next_PC, 32'h4);
    tick(); chk("arst_hold", PC_out, 32'h0);
    rst = 1'b1;
    tick(); chk("arst_4", PC_out, 32'h4);
    tick(); chk("arst_8", PC_out, 32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
